stabilizer_q2_sequencer: RTL and testbench
==========================================

# stabilizer_q2_sequencer

Producer and controller for the Q2 product register array on the stabilizer-beta path. It buffers `num_qubit` stabilizer rows and, on `start`, drives the Q2 strobe sequence: one initialize pulse, then a conditional product followed by a left-rotate for each column. With each product it presents the column-aligned row literals and the broadcast phase on the `*_stabilizer` operand lines. It sits between the stabilizer register array and the Q2 array, and replaces ad-hoc strobe generation in the top-level controller.

## Interface
- `num_qubit`, 4, number of qubits; also the number of rows and columns.
- `max_vector`, 2**num_qubit, number of Q2 vectors; the width of the phase broadcast.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  write one row into the buffer this cycle.
- `in_literals`  in  [1:0] x [0:num_qubit-1]  row literals; bit[1]=X, bit[0]=Z (00 I, 10 X, 11 Y, 01 Z).
- `in_phase`  in  1  row phase.
- `flush`  in  1  clear the row buffer (IDLE only).
- `start`  in  1  begin a sequence (IDLE and `full` only).
- `valid_P_stabilizer`  out  1  Q2 initialize pulse.
- `ld_prodQ2_from_stabilizer`  out  1  Q2 product-load pulse.
- `rotateLeft_Q2_from_stabilizer`  out  1  Q2 literal-rotate pulse.
- `literals_out_stabilizer`  out  [1:0] x [0:num_qubit-1]  product operand literals.
- `phase_out_stabilizer`  out  1 x [0:max_vector-1]  product operand phase, one bit per vector.
- `col`  out  $clog2(num_qubit)  current column.
- `busy`  out  1  high in every state except IDLE.
- `full`  out  1  buffer holds `num_qubit` rows.
- `done`  out  1  single-cycle completion pulse.

## Operation
- **Buffer.**
  - Write pointer `wr_ptr` and row count `cnt`.
  - `in_valid` in IDLE with `cnt<num_qubit` writes the row at `wr_ptr`, then increments both.
  - `full` = (`cnt==num_qubit`).
  - `in_valid` is ignored when `full` or when `busy`.
  - `flush` in IDLE sets `cnt=wr_ptr=0`. Row contents are not cleared. `flush` is ignored while `busy`.
  - `flush` takes priority over `in_valid` and over `start` in the same cycle.
- **States:** IDLE, INIT, PROD, ROT, DONE.
- **IDLE**
  - `start && full && !flush`: go to INIT. Otherwise `start` is ignored and no error is flagged.
- **INIT**
  - `valid_P_stabilizer=1`, `col=0`. Go to PROD.
- **PROD**
  - Let r = row[col].
  - If r[col][1]==1 (X pivot present):
    - `ld_prodQ2_from_stabilizer=1`.
    - `literals_out_stabilizer[j] = r[(j+col) mod num_qubit]`, i.e. the row rotated left by `col` so the pivot lands at index 0, aligned with the already-rotated Q2.
    - Every bit of `phase_out_stabilizer` = r.phase.
  - Otherwise the product is skipped: strobe low, operands zero.
  - Go to ROT.
- **ROT**
  - `rotateLeft_Q2_from_stabilizer=1`.
  - If `col==num_qubit-1`, go to DONE. Otherwise `col++` and go to PROD.
- **DONE**
  - `done=1`. Go to IDLE.
  - The buffer stays `full`, so `start` can re-run the same rows.
- **Outputs outside their state:** operands are all-zero outside PROD. At most one of the three Q2 strobes is high in any cycle.
- **Reset.** `rst` at any time, including mid-sequence:
  - State goes to IDLE; `cnt`, `wr_ptr` and `col` go to 0.
  - All outputs go to 0, including `full`, `busy` and `done`.
  - Row contents are don't-care.

## Timing
- `start` sampled at edge 0 gives:
  - INIT in cycle 1;
  - PROD in cycle 2+2c and ROT in cycle 3+2c, for c = 0..num_qubit-1;
  - DONE in cycle 2+2·num_qubit;
  - IDLE in cycle 3+2·num_qubit.
- For `num_qubit=4`: `done` is high in cycle 10, and `start` is accepted again from cycle 11.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- After `num_qubit` rotations Q2 column alignment has wrapped back to its original position. The sequencer does not emit a corrective rotate.
- Buffer write latency: a row written at edge k is visible to the sequencer from cycle k+1. `full` rises in the cycle after the last write.

## Structure
- Shared package `stab_pkg`:
  - literal encoding constants `LIT_I`, `LIT_X`, `LIT_Y`, `LIT_Z`;
  - a `literal_t` 2-bit typedef;
  - the `seq_state_t` enum.
- One sub-module, `stab_row_buffer`:
  - register file of `num_qubit` rows of `num_qubit` literals plus phase;
  - write port with pointer and count, `flush`;
  - combinational read by index.
- The FSM, rotation mux and phase broadcast live in the top module.

## Test plan
- **Load, full and overflow:** write 4 rows (row c = X on qubit c, I elsewhere, phase c[0]) -> `full=1` after the 4th write. A 5th `in_valid` changes nothing.
- **Full run:**
  - `start` -> `valid_P_stabilizer` in cycle 1.
  - Product pulses in cycles 2/4/6/8, each with `literals_out_stabilizer` = {10,00,00,00}.
  - `phase_out_stabilizer` all-0, all-1, all-0, all-1.
  - Rotates in cycles 3/5/7/9, `done` in cycle 10.
- **Pivot skip:** row 2 = {Z,Z,Z,Z} -> no product in cycle 6, rotate still in cycle 7, `done` still in cycle 10.
- **Rotation alignment:** row 1 = {Z,Y,I,X} -> operand in cycle 4 = {11,00,10,01}.
- **Gated start and flush priority:** `start` with 3 rows -> no strobes, `busy=0`. `flush` and `start` in the same cycle with a full buffer -> `cnt=0`, no sequence.
- **Reset mid-run:** `rst` in cycle 5 -> cycle 6 in IDLE with all outputs 0 and `full=0`. A subsequent reload plus `start` runs normally.

Source files
------------

// File: rtl/stab_pkg.sv
// Shared types and constants for the stabilizer-beta Q2 sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: qubit count and derived widths, the 2-bit Pauli literal
// encoding (bit[1]=X, bit[0]=Z), the sequencer state enum, and a helper
// that computes the left-rotated column index.
package stab_pkg;

  localparam int NUM_QUBIT  = 4;
  localparam int MAX_VECTOR = 2 ** NUM_QUBIT;
  localparam int COL_W      = $clog2(NUM_QUBIT);
  localparam int CNT_W      = $clog2(NUM_QUBIT + 1);

  typedef logic [1:0] literal_t;

  localparam literal_t LIT_I = 2'b00;
  localparam literal_t LIT_X = 2'b10;
  localparam literal_t LIT_Y = 2'b11;
  localparam literal_t LIT_Z = 2'b01;

  // One row of literals; index 0 occupies the most significant slot.
  typedef literal_t [0:NUM_QUBIT-1] row_lits_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PROD,
    S_ROT,
    S_DONE
  } seq_state_t;

  // Source index for output slot j when a row is rotated left by c.
  function automatic logic [COL_W-1:0] rot_idx(input int j, input logic [COL_W-1:0] c);
    return COL_W'((j + int'(c)) % NUM_QUBIT);
  endfunction

endpackage

// File: rtl/stab_row_buffer.sv
// Row buffer: holds NUM_QUBIT stabilizer rows (literals + phase) for the sequencer.
// Latency: a write at edge k is readable (and counted) from the cycle after edge k.
// Backpressure: writes are dropped once full; flush wins over a same-cycle write.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears pointer/count)
//   i_wr_en             write request (already gated to IDLE by the caller)
//   i_wr_lits/_phase    row to write at the current write pointer
//   i_flush             reset pointer and count; row storage is left as is
//   i_rd_idx            combinational read index
//   o_rd_lits/_phase    row at i_rd_idx
//   o_full              count == NUM_QUBIT
module stab_row_buffer
  import stab_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  row_lits_t        i_wr_lits,
  input  logic             i_wr_phase,
  input  logic             i_flush,
  input  logic [COL_W-1:0] i_rd_idx,
  output row_lits_t        o_rd_lits,
  output logic             o_rd_phase,
  output logic             o_full
);

  row_lits_t              r_lits [NUM_QUBIT];
  logic [0:NUM_QUBIT-1]   r_phase;
  logic [COL_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_cnt;

  logic w_full;
  logic w_wr_fire;

  assign w_full    = (r_cnt == CNT_W'(NUM_QUBIT));
  assign w_wr_fire = i_wr_en && !i_flush && !w_full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + COL_W'(1);
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Storage has no reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_lits[r_wr_ptr]  <= i_wr_lits;
      r_phase[r_wr_ptr] <= i_wr_phase;
    end
  end

  assign o_rd_lits  = r_lits[i_rd_idx];
  assign o_rd_phase = r_phase[i_rd_idx];
  assign o_full     = w_full;

endmodule

// File: rtl/stabilizer_q2_sequencer.sv
// Q2 strobe sequencer: buffers stabilizer rows and drives init / product / rotate strobes.
// Latency: start at edge 0 -> init cycle 1, product 2+2c, rotate 3+2c, done 2+2*NUM_QUBIT.
// Backpressure: none; row writes, flush and start are ignored while busy, start needs full.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_literals/in_phase   row write into the buffer (IDLE only)
//   flush                           empty the buffer (IDLE only, beats in_valid and start)
//   start                           run a sequence (IDLE and full only)
//   valid_P_stabilizer              Q2 initialize pulse
//   ld_prodQ2_from_stabilizer       Q2 product-load pulse (only when the column has an X pivot)
//   rotateLeft_Q2_from_stabilizer   Q2 literal-rotate pulse
//   literals_out_stabilizer         row[col] rotated left by col, zero outside a product
//   phase_out_stabilizer            row[col] phase broadcast to every vector, zero outside a product
//   col, busy, full, done           status
module stabilizer_q2_sequencer
  import stab_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  row_lits_t             in_literals,
  input  logic                  in_phase,
  input  logic                  flush,
  input  logic                  start,
  output logic                  valid_P_stabilizer,
  output logic                  ld_prodQ2_from_stabilizer,
  output logic                  rotateLeft_Q2_from_stabilizer,
  output row_lits_t             literals_out_stabilizer,
  output logic [0:MAX_VECTOR-1] phase_out_stabilizer,
  output logic [COL_W-1:0]      col,
  output logic                  busy,
  output logic                  full,
  output logic                  done
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_nxt;

  logic      w_idle;
  logic      w_full;
  row_lits_t w_rd_lits;
  logic      w_rd_phase;
  row_lits_t w_rot_lits;
  logic      w_pivot;

  assign w_idle = (r_state == S_IDLE);

  stab_row_buffer u_row_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (in_valid && w_idle),
    .i_wr_lits  (in_literals),
    .i_wr_phase (in_phase),
    .i_flush    (flush && w_idle),
    .i_rd_idx   (r_col),
    .o_rd_lits  (w_rd_lits),
    .o_rd_phase (w_rd_phase),
    .o_full     (w_full)
  );

  // Rotate the current row left by col so its pivot lands in slot 0,
  // matching the alignment Q2 has reached after col rotations.
  always_comb begin
    w_rot_lits = '0;
    for (int j = 0; j < NUM_QUBIT; j++) begin
      w_rot_lits[j] = w_rd_lits[rot_idx(j, r_col)];
    end
  end

  assign w_pivot = w_rd_lits[r_col][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Outputs depend on registered state and buffer contents only; the
  // buffer cannot be written outside IDLE, so nothing from the inputs
  // reaches an output in the same cycle.
  always_comb begin
    w_state_nxt                   = r_state;
    w_col_nxt                     = r_col;
    valid_P_stabilizer            = 1'b0;
    ld_prodQ2_from_stabilizer     = 1'b0;
    rotateLeft_Q2_from_stabilizer = 1'b0;
    literals_out_stabilizer       = '0;
    phase_out_stabilizer          = '0;
    done                          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && w_full && !flush) begin
          w_state_nxt = S_INIT;
          w_col_nxt   = '0;
        end
      end
      S_INIT: begin
        valid_P_stabilizer = 1'b1;
        w_col_nxt          = '0;
        w_state_nxt        = S_PROD;
      end
      S_PROD: begin
        if (w_pivot) begin
          ld_prodQ2_from_stabilizer = 1'b1;
          literals_out_stabilizer   = w_rot_lits;
          phase_out_stabilizer      = {MAX_VECTOR{w_rd_phase}};
        end
        w_state_nxt = S_ROT;
      end
      S_ROT: begin
        rotateLeft_Q2_from_stabilizer = 1'b1;
        if (r_col == COL_W'(NUM_QUBIT - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_col_nxt   = r_col + COL_W'(1);
          w_state_nxt = S_PROD;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_col_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_col_nxt   = '0;
      end
    endcase
  end

  assign col  = r_col;
  assign busy = !w_idle;
  assign full = w_full;

endmodule

// File: tb/tb_stabilizer_q2_sequencer.sv
// Bench for stabilizer_q2_sequencer: scoreboarded strobe/operand sequence checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_stabilizer_q2_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_literals;
  logic        in_phase;
  logic        flush;
  logic        start;
  logic        vp;
  logic        ld;
  logic        rl;
  logic [7:0]  lits_o;
  logic [15:0] ph_o;
  logic [1:0]  col;
  logic        busy;
  logic        full;
  logic        done;

  always #5 clk = ~clk;

  stabilizer_q2_sequencer dut (
    .clk                           (clk),
    .rst                           (rst),
    .in_valid                      (in_valid),
    .in_literals                   (in_literals),
    .in_phase                      (in_phase),
    .flush                         (flush),
    .start                         (start),
    .valid_P_stabilizer            (vp),
    .ld_prodQ2_from_stabilizer     (ld),
    .rotateLeft_Q2_from_stabilizer (rl),
    .literals_out_stabilizer       (lits_o),
    .phase_out_stabilizer          (ph_o),
    .col                           (col),
    .busy                          (busy),
    .full                          (full),
    .done                          (done)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference copy of the row buffer.
  logic [7:0] m_lits [4];
  logic       m_ph   [4];
  int         m_cnt = 0;
  int         m_wr  = 0;

  // Expected per-cycle output vectors.
  logic [31:0] sb_q [$];

  // Packing: {vp, ld, rot, busy, done, full, col[1:0], lits[7:0], phase[15:0]}
  function automatic logic [31:0] mk(input logic v, input logic l, input logic r,
                                     input logic b, input logic d, input logic f,
                                     input logic [1:0] c, input logic [7:0] li,
                                     input logic [15:0] p);
    return {v, l, r, b, d, f, c, li, p};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {vp, ld, rl, busy, done, full, col, lits_o, ph_o};
  endfunction

  function automatic logic [1:0] lit_at(input logic [7:0] row, input int j);
    return row[7-2*j -: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [7:0] li, input logic p);
    in_valid    = 1'b1;
    in_literals = li;
    in_phase    = p;
    tick();
    in_valid = 1'b0;
    if (m_cnt < 4) begin
      m_lits[m_wr] = li;
      m_ph[m_wr]   = p;
      m_wr         = (m_wr + 1) % 4;
      m_cnt++;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_cnt = 0;
    m_wr  = 0;
  endtask

  // Expected outputs for cycles 1..11 after a start sampled at edge 0.
  task automatic push_run();
    logic [7:0] r;
    logic [7:0] rot;
    logic [1:0] pl;
    logic       piv;
    sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 16'h0000));
    for (int c = 0; c < 4; c++) begin
      r   = m_lits[c];
      pl  = lit_at(r, c);
      piv = pl[1];
      rot = 8'h00;
      if (piv) begin
        for (int j = 0; j < 4; j++) rot[7-2*j -: 2] = lit_at(r, (j + c) % 4);
      end
      sb_q.push_back(mk(1'b0, piv, 1'b0, 1'b1, 1'b0, 1'b1, 2'(c), rot,
                        piv ? {16{m_ph[c]}} : 16'h0000));
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'(c), 8'h00, 16'h0000));
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'h00, 16'h0000));
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 16'h0000));
  endtask

  task automatic run_seq(input string nm, input int stop_at, output logic [7:0] c4_lits);
    logic [31:0] e;
    push_run();
    c4_lits = 8'h00;
    start   = 1'b1;
    for (int t = 1; t <= stop_at; t++) begin
      tick();
      start = 1'b0;
      e = sb_q.pop_front();
      chk($sformatf("%s_c%0d", nm, t), {32'h0, obs_vec()}, {32'h0, e});
      if (t == 4) c4_lits = lits_o;
    end
  endtask

  task automatic load_diag();
    write_row(8'b10_00_00_00, 1'b0);
    write_row(8'b00_10_00_00, 1'b1);
    write_row(8'b00_00_10_00, 1'b0);
    write_row(8'b00_00_00_10, 1'b1);
  endtask

  logic [31:0] zero_idle;
  logic [7:0]  c4;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_literals = 8'h00;
    in_phase    = 1'b0;
    flush       = 1'b0;
    start       = 1'b0;
    zero_idle   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 16'h0000);
    repeat (3) tick();
    rst = 1'b0;
    chk("reset", {32'h0, obs_vec()}, {32'h0, zero_idle});

    // Load four diagonal-X rows, checking full after each write.
    write_row(8'b10_00_00_00, 1'b0);
    chk("full_w1", {63'h0, full}, 64'd0);
    write_row(8'b00_10_00_00, 1'b1);
    chk("full_w2", {63'h0, full}, 64'd0);
    write_row(8'b00_00_10_00, 1'b0);
    chk("full_w3", {63'h0, full}, 64'd0);
    write_row(8'b00_00_00_10, 1'b1);
    chk("full_w4", {63'h0, full}, 64'd1);
    // Overflow write: must not land anywhere.
    write_row(8'b11_11_11_11, 1'b1);
    chk("full_w5", {63'h0, full}, 64'd1);

    run_seq("full_run", 11, c4);
    chk("full_run_c4_lits", {56'h0, c4}, {56'h0, 8'b10_00_00_00});

    // Pivot skip: row 2 has no X anywhere.
    do_flush();
    write_row(8'b10_00_00_00, 1'b0);
    write_row(8'b00_10_00_00, 1'b1);
    write_row(8'b01_01_01_01, 1'b1);
    write_row(8'b00_00_00_10, 1'b1);
    run_seq("pivot_skip", 11, c4);

    // Rotation alignment: row 1 = {Z,Y,I,X}.
    do_flush();
    write_row(8'b10_00_00_00, 1'b0);
    write_row(8'b01_11_00_10, 1'b1);
    write_row(8'b00_00_10_00, 1'b0);
    write_row(8'b00_00_00_10, 1'b1);
    run_seq("rot_align", 11, c4);
    chk("rot_align_c4_lits", {56'h0, c4}, {56'h0, 8'b11_00_10_01});

    // Gated start with only three rows.
    do_flush();
    write_row(8'b10_00_00_00, 1'b0);
    write_row(8'b00_10_00_00, 1'b1);
    write_row(8'b00_00_10_00, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      chk($sformatf("gated_start_c%0d", t), {32'h0, obs_vec()}, {32'h0, zero_idle});
      tick();
    end

    // Flush beats start on a full buffer.
    write_row(8'b00_00_00_10, 1'b1);
    chk("flush_pre_full", {63'h0, full}, 64'd1);
    flush = 1'b1;
    start = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    m_cnt = 0;
    m_wr  = 0;
    for (int t = 1; t <= 3; t++) begin
      chk($sformatf("flush_start_c%0d", t), {32'h0, obs_vec()}, {32'h0, zero_idle});
      tick();
    end

    // Reset in cycle 5 of a run.
    load_diag();
    run_seq("mid_rst", 5, c4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    m_cnt = 0;
    m_wr  = 0;
    chk("mid_rst_c6", {32'h0, obs_vec()}, {32'h0, zero_idle});

    // Reload and run again normally.
    load_diag();
    run_seq("after_rst", 11, c4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
